// File: rtl/risc_lsu_pkg.sv
// rtl/risc_lsu_pkg.sv - shared encodings and alignment helper for the MEM-stage load/store unit
package risc_lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WRITE  = 2'd2
    } state_e;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_HALF: return lo[0];
            SZ_WORD: return (lo != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - little-endian lane extract/extend for loads and lane merge for stores
module lsu_lane_align
    import risc_lsu_pkg::*;
(
    input  logic [31:0] rword_i,
    input  logic [1:0]  lo_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merged_o
);

    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;
    logic [31:0] rshift;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign byte_sh = {lo_i, 3'b000};
    assign half_sh = {lo_i[1], 4'b0000};
    assign rshift  = rword_i >> byte_sh;
    assign byte_v  = rshift[7:0];
    assign half_v  = lo_i[1] ? rword_i[31:16] : rword_i[15:0];

    always_comb begin
        load_o = 32'd0;
        case (size_i)
            SZ_BYTE: load_o = {{24{signed_i & byte_v[7]}}, byte_v};
            SZ_HALF: load_o = {{16{signed_i & half_v[15]}}, half_v};
            SZ_WORD: load_o = rword_i;
            default: load_o = 32'd0;
        endcase
    end

    // Only the addressed lane is replaced; the remaining bytes come from the current memory word.
    always_comb begin
        merged_o = rword_i;
        case (size_i)
            SZ_BYTE: merged_o = (rword_i & ~(32'h0000_00FF << byte_sh)) | ({24'd0, wdata_i[7:0]} << byte_sh);
            SZ_HALF: merged_o = (rword_i & ~(32'h0000_FFFF << half_sh)) | ({16'd0, wdata_i[15:0]} << half_sh);
            SZ_WORD: merged_o = wdata_i;
            default: merged_o = rword_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store FSM: capture, range/alignment check, access, sub-word RMW
module mem_access_unit
    import risc_lsu_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [1:0]    req_size,
    input  logic          req_signed,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    output logic          resp_valid,
    output logic          resp_err,
    output logic [31:0]   resp_rdata,
    output logic [31:0]   mem_addr,
    output logic          mem_mw,
    output logic [31:0]   mem_datain,
    input  logic [31:0]   mem_dataout
);

    localparam logic [AW-3:0] DEPTH_W = (AW-2)'(DEPTH);

    state_e        state_q, state_d;
    logic          wr_q;
    logic [1:0]    size_q;
    logic          sgn_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   merged_q, merged_d;
    logic          resp_valid_q, resp_valid_d;
    logic          resp_err_q, resp_err_d;
    logic [31:0]   resp_rdata_q, resp_rdata_d;

    logic          accept;
    logic          req_err;
    logic [31:0]   load_word;
    logic [31:0]   merged_word;

    assign accept  = req_valid && (state_q == ST_IDLE);
    assign req_err = (req_size == SZ_RSVD) || is_misaligned(req_size, req_addr[1:0]) ||
                     (req_addr[AW-1:2] >= DEPTH_W);

    lsu_lane_align u_align (
        .rword_i  (mem_dataout),
        .lo_i     (addr_q[1:0]),
        .size_i   (size_q),
        .signed_i (sgn_q),
        .wdata_i  (wdata_q),
        .load_o   (load_word),
        .merged_o (merged_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            wr_q         <= 1'b0;
            size_q       <= SZ_BYTE;
            sgn_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= 32'd0;
            merged_q     <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            merged_q     <= merged_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            if (accept) begin
                wr_q    <= req_write;
                size_q  <= req_size;
                sgn_q   <= req_signed;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept && !req_err) state_d = ST_ACCESS;
            ST_ACCESS: state_d = (wr_q && (size_q != SZ_WORD)) ? ST_WRITE : ST_IDLE;
            ST_WRITE:  state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Response registers pulse for one cycle; rdata is zero outside a completing load.
    always_comb begin
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'd0;
        merged_d     = merged_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && req_err) begin
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                end
            end
            ST_ACCESS: begin
                merged_d = merged_word;
                if (!wr_q) begin
                    resp_valid_d = 1'b1;
                    resp_rdata_d = load_word;
                end else if (size_q == SZ_WORD) begin
                    resp_valid_d = 1'b1;
                end
            end
            ST_WRITE: resp_valid_d = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        req_ready  = (state_q == ST_IDLE);
        mem_mw     = ((state_q == ST_ACCESS) && wr_q && (size_q == SZ_WORD)) || (state_q == ST_WRITE);
        mem_datain = (state_q == ST_WRITE) ? merged_q : wdata_q;
        mem_addr   = 32'(addr_q[AW-1:2]);
        resp_valid = resp_valid_q;
        resp_err   = resp_err_q;
        resp_rdata = resp_rdata_q;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit paired with a 64-word data memory
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr;
    logic        mem_mw;
    logic [31:0] mem_datain;
    logic [31:0] mem_dataout;

    logic        init_mem = 1'b1;
    logic [31:0] dmem    [64];
    logic [31:0] ref_mem [64];

    int cyc = 0;
    int vectors = 0;
    int errors = 0;
    int mw_cycles = 0;
    int exp_writes = 0;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          acc;
        int          lat;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    mem_access_unit #(.DEPTH(64), .AW(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_size    (req_size),
        .req_signed  (req_signed),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_err    (resp_err),
        .resp_rdata  (resp_rdata),
        .mem_addr    (mem_addr),
        .mem_mw      (mem_mw),
        .mem_datain  (mem_datain),
        .mem_dataout (mem_dataout)
    );

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 64; i++) dmem[i] <= 32'(i);
        end else if (mem_mw) begin
            dmem[mem_addr[5:0]] <= mem_datain;
        end
    end
    assign mem_dataout = dmem[mem_addr[5:0]];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference behaviour from the addressing rules, using plain arithmetic on a word array.
    task automatic model(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                         input logic [31:0] wd, output logic err, output logic [31:0] rd, output int lat);
        int          idx;
        int          sh;
        logic [31:0] old, v, lane_mask;
        err = (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0) || ((a / 4) >= 64);
        rd  = 32'd0;
        lat = 1;
        if (!err) begin
            idx = int'(a / 4);
            sh  = 8 * int'(a % 4);
            old = ref_mem[idx];
            if (!w) begin
                lat = 2;
                if (sz == 2'd0) begin
                    v = (old >> sh) & 32'hFF;
                    if (sg && v >= 32'd128) v = v + 32'hFFFF_FF00;
                end else if (sz == 2'd1) begin
                    v = (old >> sh) & 32'hFFFF;
                    if (sg && v >= 32'd32768) v = v + 32'hFFFF_0000;
                end else begin
                    v = old;
                end
                rd = v;
            end else begin
                exp_writes++;
                if (sz == 2'd2) begin
                    ref_mem[idx] = wd;
                    lat = 2;
                end else begin
                    lane_mask = (sz == 2'd0) ? 32'hFF : 32'hFFFF;
                    ref_mem[idx] = (old & ~(lane_mask << sh)) | ((wd & lane_mask) << sh);
                    lat = 3;
                end
            end
        end
    endtask

    task automatic issue(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                         input logic [31:0] wd, output int acc);
        logic        e;
        logic [31:0] r;
        int          l;
        int          budget;
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = w;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        budget = 0;
        while (!req_ready && budget < 10) begin
            @(negedge clk);
            budget++;
        end
        acc = cyc;
        if (!req_ready) begin
            vectors++;
            errors++;
            $display("FAIL accept_timeout: req_ready stuck at %b, required 1", req_ready);
            req_valid = 1'b0;
            return;
        end
        model(w, sz, sg, a, wd, e, r, l);
        exp_q.push_back('{err: e, rdata: r, acc: acc, lat: l});
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 1; i < n; i++) @(negedge clk);
    endtask

    task automatic drain();
        int budget = 0;
        while (exp_q.size() != 0 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        check("drain_pending", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_mw) mw_cycles++;
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_resp_valid", 32'(resp_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("resp_err", 32'(resp_err), 32'(e.err));
                    check("resp_rdata", resp_rdata, e.rdata);
                    check("resp_latency", 32'(cyc - e.acc), 32'(e.lat));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int a0, a1, a2, acc;
        logic        rw, rs;
        logic [1:0]  rsz;
        logic [31:0] ra;
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'(i);

        repeat (3) @(negedge clk);
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_resp_valid", 32'(resp_valid), 32'd0);
        check("reset_resp_err", 32'(resp_err), 32'd0);
        check("reset_resp_rdata", resp_rdata, 32'd0);
        check("reset_mem_mw", 32'(mem_mw), 32'd0);
        check("reset_mem_addr", mem_addr, 32'd0);
        rst = 1'b0;
        init_mem = 1'b0;
        @(negedge clk);

        issue(1'b0, 2'b10, 1'b0, 32'h14, 32'd0, acc);
        idle(1); drain();
        check("lw_no_write", 32'(mw_cycles), 32'd0);

        issue(1'b1, 2'b00, 1'b0, 32'h09, 32'hAB, acc);
        idle(1); drain();
        check("sb_write_cycles", 32'(mw_cycles), 32'd1);
        check("sb_word2", dmem[2], 32'h0000_AB02);
        issue(1'b0, 2'b00, 1'b1, 32'h09, 32'd0, acc);
        issue(1'b0, 2'b00, 1'b0, 32'h09, 32'd0, acc);
        idle(1); drain();

        issue(1'b1, 2'b01, 1'b0, 32'h06, 32'h8001, acc);
        idle(1); drain();
        check("sh_word1", dmem[1], 32'h8001_0001);
        issue(1'b0, 2'b01, 1'b1, 32'h06, 32'd0, acc);
        issue(1'b0, 2'b01, 1'b1, 32'h03, 32'd0, acc);
        idle(1); drain();

        issue(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEAD_BEEF, acc);
        issue(1'b0, 2'b11, 1'b0, 32'h10, 32'd0, acc);
        idle(1); drain();
        check("range_no_write", 32'(mw_cycles), 32'(exp_writes));

        // Reset lands while the sub-word store sits in its write cycle.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h0C; req_wdata = 32'h55;
        check("rst_pre_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rst_write_state_mw", 32'(mem_mw), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mw_drop", 32'(mem_mw), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_ready_after", 32'(req_ready), 32'd1);
        repeat (5) @(negedge clk);
        check("rst_word3", dmem[3], 32'h0000_0003);

        issue(1'b0, 2'b10, 1'b0, 32'h0, 32'd0, a0);
        issue(1'b0, 2'b10, 1'b0, 32'h4, 32'd0, a1);
        issue(1'b0, 2'b10, 1'b0, 32'h8, 32'd0, a2);
        idle(1); drain();
        check("b2b_spacing_1", 32'(a1 - a0), 32'd2);
        check("b2b_spacing_2", 32'(a2 - a1), 32'd2);

        for (int n = 0; n < 150; n++) begin
            rw  = 1'($urandom % 2);
            rs  = 1'($urandom % 2);
            rsz = ($urandom % 8 == 0) ? 2'b11 : 2'($urandom % 3);
            ra  = 32'($urandom_range(0, 255));
            if ($urandom % 4 != 0) begin
                if (rsz == 2'b01) ra = ra & ~32'd1;
                else if (rsz == 2'b10) ra = ra & ~32'd3;
            end
            if ($urandom % 12 == 0) ra = 32'd256 + 32'($urandom_range(0, 1023));
            issue(rw, rsz, rs, ra, $urandom, acc);
            if ($urandom % 2 == 0) idle($urandom_range(1, 3));
        end
        idle(1); drain();

        check("write_cycle_count", 32'(mw_cycles), 32'(exp_writes));
        for (int i = 0; i < 64; i++) check($sformatf("final_word_%0d", i), dmem[i], ref_mem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
